// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the async-FIFO write-port arbiter.
// Holds the arbiter state encoding, index-width helper and watchdog counter width.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // The watchdog counter is sized once here, so WD_MAX must stay below 2**WD_CNT_W.
    localparam int WD_CNT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_last+1 (mod NREQ).
// The request vector is doubled so a plain part-select performs the rotation.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_last,
    output logic [IDXW-1:0] pick,
    output logic            any_req
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDXW:0]     start;
    logic [IDXW:0]     offset;
    logic [IDXW:0]     sum;

    // NOTE: every variable is assigned before any branch, so no latch can be inferred.
    always_comb begin
        req_dbl = {req, req};
        start   = {1'b0, rr_last} + (IDXW+1)'(1);
        req_rot = req_dbl[start +: NREQ];
        offset  = '0;
        // Descending scan leaves the lowest set bit, i.e. the nearest requester.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = (IDXW+1)'(i);
            end
        end
        sum = start + offset;
        if (sum >= (IDXW+1)'(NREQ)) begin
            sum = sum - (IDXW+1)'(NREQ);
        end
        pick    = sum[IDXW-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port; bursts are atomic.
// Optional stall watchdog with wd_abort output is enabled by defining ARB_WATCHDOG_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DW     = 8,
    parameter int WD_MAX = 64
) (
    input  logic                   clk,
    input  logic                   wresetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [NREQ*DW-1:0]     din,
    input  logic                   full,
    output logic [NREQ-1:0]        gnt,
    output logic                   winc,
    output logic [DW-1:0]          wdata,
    output logic [idx_w(NREQ)-1:0] owner,
`ifdef ARB_WATCHDOG_EN
    output logic                   wd_abort,
`endif
    output logic                   busy
);

    localparam int IDXW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("fifo_wr_arbiter: NREQ must be in 2..16");
    end
    if (WD_MAX < 1 || WD_MAX >= 2**WD_CNT_W) begin : g_bad_wd_max
        $error("fifo_wr_arbiter: WD_MAX out of counter range");
    end

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] rr_last_q, rr_last_d;
    logic [IDXW-1:0] pick;
    logic            any_req;
    logic            acc;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req     (req),
        .rr_last (rr_last_q),
        .pick    (pick),
        .any_req (any_req)
    );

`ifdef ARB_WATCHDOG_EN
    logic [WD_CNT_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        gnt       = '0;
        winc      = 1'b0;
        wdata     = '0;
        acc       = 1'b0;
        busy      = (state_q == BURST);
`ifdef ARB_WATCHDOG_EN
        wd_cnt_d  = '0;
        wd_abort  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                // full gates the beat here so winc never reaches a full FIFO.
                acc          = req[owner_q] & ~full;
                gnt[owner_q] = acc;
                winc         = acc;
                wdata        = din[int'(owner_q)*DW +: DW];
                if (acc && last[owner_q]) begin
                    rr_last_d = owner_q;
                    state_d   = IDLE;
                end
`ifdef ARB_WATCHDOG_EN
                if (!req[owner_q]) begin
                    if (wd_cnt_q == WD_CNT_W'(WD_MAX - 1)) begin
                        wd_abort  = 1'b1;
                        rr_last_d = owner_q;
                        state_d   = IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + WD_CNT_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge wresetn) begin
        if (!wresetn) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_last_q <= IDXW'(NREQ - 1);
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
`endif
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue-based producers and a burst-level reference model.
// Define ARB_WATCHDOG_EN to exercise the watchdog instead of the indefinite lock-hold case.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int WDM   = 8;
    localparam int IW    = 2;
    localparam int OBS_W = N + 1 + DW + 1 + IW;

    logic            clk = 1'b0;
    logic            wresetn;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] din;
    logic            full;
    logic [N-1:0]    gnt;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   owner;
    logic            busy;
`ifdef ARB_WATCHDOG_EN
    logic            wd_abort;
`endif

    fifo_wr_arbiter #(
        .NREQ   (N),
        .DW     (DW),
        .WD_MAX (WDM)
    ) dut (
        .clk      (clk),
        .wresetn  (wresetn),
        .req      (req),
        .last     (last),
        .din      (din),
        .full     (full),
        .gnt      (gnt),
        .winc     (winc),
        .wdata    (wdata),
        .owner    (owner),
`ifdef ARB_WATCHDOG_EN
        .wd_abort (wd_abort),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t pq [N][$];
    bit    hold [N];
    bit    full_v;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one burst at a time, owner chosen by scanning from the pointer.
    bit m_active;
    int m_owner;
    int m_ptr;
    int m_idle;

    int obs_winc;
    int obs_gnt;
    int obs_starts[$];
    bit prev_busy;
    bit obs_abort;
    int total_pushed;

    function automatic void push_burst(input int p, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.last = (k == len - 1);
            pq[p].push_back(b);
            total_pushed++;
        end
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && !hold[i]) begin
                req[i]             = 1'b1;
                din[i*DW +: DW]    = pq[i][0].data;
                last[i]            = pq[i][0].last;
            end else begin
                req[i]             = 1'b0;
                din[i*DW +: DW]    = DW'($urandom);
                last[i]            = 1'($urandom);
            end
        end
        full = full_v;
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_owner   = 0;
        m_ptr     = N - 1;
        m_idle    = 0;
        prev_busy = 1'b0;
    endtask

    // One clock: drive, predict, compare at negedge, then retire accepted beats.
    task automatic cycle();
        logic [N-1:0]     e_gnt;
        logic             e_winc;
        logic             e_abort;
        logic [DW-1:0]    e_wdata;
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] exp_v;
        bit               n_active;
        int               n_owner, n_ptr, n_idle, pop;
        drive_inputs();
        @(negedge clk);
        e_gnt = '0; e_winc = 1'b0; e_wdata = '0; e_abort = 1'b0;
        n_active = m_active; n_owner = m_owner; n_ptr = m_ptr; n_idle = 0; pop = -1;
        if (!m_active) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c]) begin
                    n_owner  = c;
                    n_active = 1'b1;
                    break;
                end
            end
        end else begin
            e_wdata = din[m_owner*DW +: DW];
            if (req[m_owner] && !full_v) begin
                e_winc         = 1'b1;
                e_gnt[m_owner] = 1'b1;
                pop            = m_owner;
                if (pq[m_owner][0].last) begin
                    n_active = 1'b0;
                    n_ptr    = m_owner;
                end
            end
`ifdef ARB_WATCHDOG_EN
            else if (!req[m_owner]) begin
                n_idle = m_idle + 1;
                if (n_idle == WDM) begin
                    e_abort  = 1'b1;
                    n_active = 1'b0;
                    n_ptr    = m_owner;
                    n_idle   = 0;
                end
            end
`endif
        end
        exp_v = {e_gnt, e_winc, e_wdata, m_active, IW'(m_owner)};
        obs   = {gnt, winc, wdata, busy, owner};
        compared++;
        if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL cycle_outputs @%0t: got gnt=%b winc=%b wdata=%h busy=%b owner=%0d, want gnt=%b winc=%b wdata=%h busy=%b owner=%0d",
                     $time, gnt, winc, wdata, busy, owner, e_gnt, e_winc, e_wdata, m_active, m_owner);
        end
`ifdef ARB_WATCHDOG_EN
        compared++;
        if (wd_abort !== e_abort) begin
            mismatched++;
            $display("FAIL wd_abort @%0t: got %b want %b", $time, wd_abort, e_abort);
        end
        obs_abort = (wd_abort === 1'b1);
`endif
        if (winc === 1'b1) obs_winc++;
        if (gnt !== '0) obs_gnt++;
        if (busy === 1'b1 && !prev_busy) obs_starts.push_back(int'(owner));
        prev_busy = (busy === 1'b1);
        @(posedge clk);
        #1;
        if (pop >= 0) void'(pq[pop].pop_front());
        m_active = n_active;
        m_owner  = n_owner;
        m_ptr    = n_ptr;
        m_idle   = n_idle;
    endtask

    task automatic do_reset();
        wresetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            hold[i] = 1'b0;
        end
        full_v = 1'b0;
        drive_inputs();
        model_reset();
        obs_starts.delete();
        obs_winc = 0;
        obs_gnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        wresetn = 1'b1;
    endtask

    task automatic run_until_writes(input int target);
        int k;
        k = 0;
        while (obs_winc < target && k < 60) begin
            cycle();
            k++;
        end
        compared++;
        if (obs_winc < target) begin
            mismatched++;
            $display("FAIL write_timeout: got %0d writes want %0d", obs_winc, target);
        end
    endtask

    task automatic drain(input int budget);
        int  k;
        bit  pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < budget) begin
            pending = m_active;
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) pending = 1'b1;
            if (pending) begin
                cycle();
                k++;
            end
        end
        compared++;
        if (pending) begin
            mismatched++;
            $display("FAIL drain_timeout: got still pending after %0d cycles want drained", k);
        end
    endtask

    task automatic check_starts(input string name, input int exp_q[$]);
        compared++;
        if (obs_starts.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL %s_count: got %0d bursts want %0d", name, obs_starts.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                compared++;
                if (obs_starts[i] != exp_q[i]) begin
                    mismatched++;
                    $display("FAIL %s[%0d]: got owner %0d want %0d", name, i, obs_starts[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        wresetn = 1'b0;
        push_burst(2, 1);
        drive_inputs();
        #3;
        compared++; if (gnt !== '0)   begin mismatched++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        compared++; if (winc !== 1'b0) begin mismatched++; $display("FAIL reset_winc: got %b want 0", winc); end
        compared++; if (wdata !== '0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (owner !== '0) begin mismatched++; $display("FAIL reset_owner: got %0d want 0", owner); end
        do_reset();
    endtask

    task automatic test_single_burst();
        int exp_q[$];
        do_reset();
        push_burst(0, 3);
        drain(20);
        repeat (2) cycle();
        compared++;
        if (obs_winc != 3) begin
            mismatched++;
            $display("FAIL single_burst_writes: got %0d want 3", obs_winc);
        end
        exp_q = '{0};
        check_starts("single_burst_owner", exp_q);
    endtask

    task automatic test_rr_wrap();
        int exp_q[$];
        do_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_burst(i, 1);
        repeat (16) cycle();
        compared++;
        if (obs_winc != 8 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_timing: got %0d writes busy=%b want 8 writes busy=0", obs_winc, busy);
        end
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_starts("rr_order", exp_q);
    endtask

    task automatic test_full_stall();
        int w0, g0;
        do_reset();
        push_burst(2, 6);
        run_until_writes(2);
        full_v = 1'b1;
        w0 = obs_winc;
        g0 = obs_gnt;
        repeat (5) cycle();
        compared++;
        if (obs_winc != w0 || obs_gnt != g0) begin
            mismatched++;
            $display("FAIL full_stall: got %0d writes %0d grants during full want 0", obs_winc - w0, obs_gnt - g0);
        end
        full_v = 1'b0;
        drain(20);
        compared++;
        if (obs_winc != 6) begin
            mismatched++;
            $display("FAIL full_stall_total: got %0d writes want 6", obs_winc);
        end
    endtask

`ifndef ARB_WATCHDOG_EN
    task automatic test_req_drop();
        int g0;
        int exp_q[$];
        do_reset();
        push_burst(1, 4);
        run_until_writes(1);
        push_burst(0, 2);
        push_burst(3, 2);
        hold[1] = 1'b1;
        g0 = obs_gnt;
        for (int k = 0; k < 10; k++) begin
            cycle();
            compared++;
            if (owner !== IW'(1) || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL req_drop_lock: got owner=%0d busy=%b want owner=1 busy=1", owner, busy);
            end
        end
        compared++;
        if (obs_gnt != g0) begin
            mismatched++;
            $display("FAIL req_drop_grants: got %0d want 0", obs_gnt - g0);
        end
        hold[1] = 1'b0;
        drain(40);
        exp_q = '{1, 3, 0};
        check_starts("req_drop_order", exp_q);
    endtask
`else
    task automatic test_watchdog();
        int k;
        int exp_q[$];
        do_reset();
        push_burst(0, 4);
        run_until_writes(1);
        push_burst(1, 2);
        hold[0] = 1'b1;
        obs_abort = 1'b0;
        k = 0;
        while (!obs_abort && k < 20) begin
            cycle();
            k++;
        end
        compared++;
        if (!obs_abort || k != WDM) begin
            mismatched++;
            $display("FAIL wd_abort_timing: got abort=%b on idle cycle %0d want abort on cycle %0d", obs_abort, k, WDM);
        end
        hold[0] = 1'b0;
        obs_starts.delete();
        drain(40);
        exp_q = '{1, 0};
        check_starts("wd_next_owner", exp_q);
    endtask
`endif

    task automatic test_reset_mid_burst();
        int exp_q[$];
        do_reset();
        push_burst(1, 5);
        run_until_writes(2);
        drive_inputs();
        #2;
        wresetn = 1'b0;
        #1;
        compared++; if (gnt !== '0)    begin mismatched++; $display("FAIL midrst_gnt: got %b want 0", gnt); end
        compared++; if (winc !== 1'b0) begin mismatched++; $display("FAIL midrst_winc: got %b want 0", winc); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
        compared++; if (owner !== '0)  begin mismatched++; $display("FAIL midrst_owner: got %0d want 0", owner); end
        compared++; if (wdata !== '0)  begin mismatched++; $display("FAIL midrst_wdata: got %h want 0", wdata); end
        model_reset();
        @(posedge clk);
        #1;
        wresetn = 1'b1;
        obs_starts.delete();
        push_burst(0, 2);
        push_burst(2, 2);
        drain(40);
        exp_q = '{0, 1, 2};
        check_starts("midrst_order", exp_q);
    endtask

    task automatic test_random();
        do_reset();
        total_pushed = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = int'($urandom_range(0, N - 1));
                if (pq[p].size() < 8) push_burst(p, int'($urandom_range(1, 5)));
            end
            full_v = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) hold[i] = !hold[i];
            cycle();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        full_v = 1'b0;
        drain(600);
        compared++;
        if (obs_winc != total_pushed) begin
            mismatched++;
            $display("FAIL random_total: got %0d writes want %0d", obs_winc, total_pushed);
        end
    endtask

    initial begin
        wresetn = 1'b0;
        req = '0; last = '0; din = '0; full = 1'b0;
        full_v = 1'b0;
        total_pushed = 0;
        model_reset();
        test_reset();
        test_single_burst();
        test_rr_wrap();
        test_full_stall();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_req_drop();
`endif
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
